// File: rtl/cpu_defs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs_pkg
// Definitions shared by the CPU control blocks:
//   - icu_state_t : interrupt control unit sequencer states
//   - ALU_*       : ALU function codes the ICU drives while it owns the datapath
//   - CCR_*       : bit positions of the condition code register {C,N,Z}
//   - VECTOR_ADDR_DEFAULT : data-memory word holding the ISR entry PC
// -----------------------------------------------------------------------------
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        ICU_IDLE     = 3'd0,
        ICU_DRAIN    = 3'd1,
        ICU_PUSH_HI  = 3'd2,
        ICU_PUSH_LO  = 3'd3,
        ICU_PUSH_FLG = 3'd4,
        ICU_VECTOR   = 3'd5,
        ICU_IN_ISR   = 3'd6
    } icu_state_t;

    localparam logic [3:0] ALU_NONE     = 4'b0000;
    localparam logic [3:0] ALU_PASS_OP2 = 4'b0100;

    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    localparam int VECTOR_ADDR_DEFAULT = 0;

endpackage : cpu_defs_pkg

// File: rtl/int_edge_latch.sv
// -----------------------------------------------------------------------------
// int_edge_latch
// Registers the external interrupt pin, detects its rising edge and holds a
// one-deep pending request until the sequencer accepts it.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   i_int_req   in   external interrupt pin
//   i_clear     in   sequencer is accepting the pending request this cycle
//   o_pending   out  request latched but not yet accepted
// -----------------------------------------------------------------------------
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic i_int_req,
    input  logic i_clear,
    output logic o_pending
);

    logic r_int_q;
    logic r_pending;
    logic w_rise;

    assign w_rise = i_int_req & ~r_int_q;

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_q   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_int_q <= i_int_req;
            // A rise wins over a same-cycle clear; a rise while already
            // pending simply leaves the single request in place.
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule : int_edge_latch

// File: rtl/interrupt_ctrl_unit.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_unit
// Takes an external interrupt at an instruction boundary, lets in-flight
// instructions retire, then borrows the shared stack/memory control lines
// (int_flag=1) to push PC high word, PC low word and flags, loads the ISR
// vector, and masks further service until RTI commits.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   int_req            external interrupt pin (rising edge requests service)
//   instr_boundary     fetch is at the first word of an instruction
//   mem_stall          data memory busy; sequencer holds state and outputs
//   rti_commit         RTI writeback pulse; leaves the ISR
//   pc_in, flags_in    return PC and CCR to save
//   int_flag           ICU owns the shared control lines
//   stall_fetch,flush  freeze fetch and inject NOPs into decode
//   stack_operation, push_pop, write_sp, DMW, DMR, alu_function,
//   push_data, mem_addr, vector_load   datapath controls while int_flag=1
//   int_pending        request latched but not yet serviced
//
// PC_WIDTH must equal 2*DATA_WIDTH: the PC is saved as exactly two words.
// -----------------------------------------------------------------------------
module interrupt_ctrl_unit
    import cpu_defs_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int FLAG_WIDTH   = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int VECTOR_ADDR  = VECTOR_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  int_req,
    input  logic                  instr_boundary,
    input  logic                  mem_stall,
    input  logic                  rti_commit,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [FLAG_WIDTH-1:0] flags_in,
    output logic                  int_flag,
    output logic                  stall_fetch,
    output logic                  flush,
    output logic                  stack_operation,
    output logic                  push_pop,
    output logic                  write_sp,
    output logic                  DMW,
    output logic                  DMR,
    output logic [3:0]            alu_function,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  vector_load,
    output logic                  int_pending
);

    // Drain counter counts DRAIN_CYCLES-1 down to 0.
    localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic                  int_flag;
        logic                  stall_fetch;
        logic                  flush;
        logic                  stack_operation;
        logic                  push_pop;
        logic                  write_sp;
        logic                  dmw;
        logic                  dmr;
        logic [3:0]            alu_function;
        logic [DATA_WIDTH-1:0] push_data;
        logic [DATA_WIDTH-1:0] mem_addr;
        logic                  vector_load;
    } icu_out_t;

    icu_state_t            r_state;
    logic [CNT_W-1:0]      r_drain_cnt;
    logic [PC_WIDTH-1:0]   r_saved_pc;
    logic [FLAG_WIDTH-1:0] r_saved_flags;
    icu_out_t              r_out;

    logic w_pending;
    logic w_take;

    // Accept a request only at a clean boundary with memory idle.
    assign w_take = (r_state == ICU_IDLE) & w_pending & instr_boundary & ~mem_stall;

    int_edge_latch u_edge_latch (
        .clk       (clk),
        .rst       (rst),
        .i_int_req (int_req),
        .i_clear   (w_take),
        .o_pending (w_pending)
    );

    // Output pattern for the state being entered. Outputs are registered, so
    // each transition loads the pattern of its destination state and a held
    // state (mem_stall) keeps its outputs untouched.
    function automatic icu_out_t f_decode(
        input icu_state_t            s,
        input logic [PC_WIDTH-1:0]   pc,
        input logic [FLAG_WIDTH-1:0] fl
    );
        icu_out_t o;
        // NOTE: blocking assignment here is correct -- this is combinational
        // evaluation on a local variable, not a stored state update.
        o = '0;
        case (s)
            ICU_DRAIN: begin
                o.stall_fetch = 1'b1;
                o.flush       = 1'b1;
            end
            ICU_PUSH_HI, ICU_PUSH_LO, ICU_PUSH_FLG: begin
                o.int_flag        = 1'b1;
                o.stall_fetch     = 1'b1;
                o.flush           = 1'b1;
                o.stack_operation = 1'b1;
                o.push_pop        = 1'b1;
                o.write_sp        = 1'b1;
                o.dmw             = 1'b1;
                o.alu_function    = ALU_PASS_OP2;
                if (s == ICU_PUSH_HI) begin
                    o.push_data = pc[PC_WIDTH-1 -: DATA_WIDTH];
                end else if (s == ICU_PUSH_LO) begin
                    o.push_data = pc[DATA_WIDTH-1:0];
                end else begin
                    o.push_data = DATA_WIDTH'(fl);
                end
            end
            ICU_VECTOR: begin
                o.int_flag     = 1'b1;
                o.stall_fetch  = 1'b1;
                o.flush        = 1'b1;
                o.dmr          = 1'b1;
                o.mem_addr     = DATA_WIDTH'(VECTOR_ADDR);
                o.vector_load  = 1'b1;
                o.alu_function = ALU_NONE;
            end
            default: ;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the saved PC/flags are datapath registers but are reset
            // anyway so push_data can never carry X after reset.
            r_state       <= ICU_IDLE;
            r_drain_cnt   <= '0;
            r_saved_pc    <= '0;
            r_saved_flags <= '0;
            r_out         <= '0;
        end else begin
            case (r_state)
                ICU_IDLE: begin
                    if (w_take) begin
                        r_state     <= ICU_DRAIN;
                        r_saved_pc  <= pc_in;
                        r_drain_cnt <= DRAIN_LOAD;
                        r_out       <= f_decode(ICU_DRAIN, pc_in, r_saved_flags);
                    end
                end
                ICU_DRAIN: begin
                    if (!mem_stall) begin
                        if (r_drain_cnt == '0) begin
                            // Flags are sampled after the pipeline has drained
                            // so they reflect the last retired instruction.
                            r_saved_flags <= flags_in;
                            r_state       <= ICU_PUSH_HI;
                            r_out         <= f_decode(ICU_PUSH_HI, r_saved_pc, flags_in);
                        end else begin
                            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
                        end
                    end
                end
                ICU_PUSH_HI: begin
                    if (!mem_stall) begin
                        r_state <= ICU_PUSH_LO;
                        r_out   <= f_decode(ICU_PUSH_LO, r_saved_pc, r_saved_flags);
                    end
                end
                ICU_PUSH_LO: begin
                    if (!mem_stall) begin
                        r_state <= ICU_PUSH_FLG;
                        r_out   <= f_decode(ICU_PUSH_FLG, r_saved_pc, r_saved_flags);
                    end
                end
                ICU_PUSH_FLG: begin
                    if (!mem_stall) begin
                        r_state <= ICU_VECTOR;
                        r_out   <= f_decode(ICU_VECTOR, r_saved_pc, r_saved_flags);
                    end
                end
                ICU_VECTOR: begin
                    if (!mem_stall) begin
                        r_state <= ICU_IN_ISR;
                        r_out   <= f_decode(ICU_IN_ISR, r_saved_pc, r_saved_flags);
                    end
                end
                ICU_IN_ISR: begin
                    // Service is masked here; a request latched meanwhile is
                    // picked up from IDLE at the next boundary.
                    if (rti_commit) begin
                        r_state <= ICU_IDLE;
                        r_out   <= f_decode(ICU_IDLE, r_saved_pc, r_saved_flags);
                    end
                end
                default: begin
                    r_state <= ICU_IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign int_flag        = r_out.int_flag;
    assign stall_fetch     = r_out.stall_fetch;
    assign flush           = r_out.flush;
    assign stack_operation = r_out.stack_operation;
    assign push_pop        = r_out.push_pop;
    assign write_sp        = r_out.write_sp;
    assign DMW             = r_out.dmw;
    assign DMR             = r_out.dmr;
    assign alu_function    = r_out.alu_function;
    assign push_data       = r_out.push_data;
    assign mem_addr        = r_out.mem_addr;
    assign vector_load     = r_out.vector_load;
    assign int_pending     = w_pending;

endmodule : interrupt_ctrl_unit

// File: tb/tb_interrupt_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ctrl_unit
// Directed scenarios followed by random stimulus. A reference model tracks
// the service as a step number (0 idle, 1..D drain, D+1..D+3 pushes, D+4
// vector, D+5 in ISR) and derives every expected output from that number.
// -----------------------------------------------------------------------------
module tb_interrupt_ctrl_unit;
    import cpu_defs_pkg::*;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst, int_req, instr_boundary, mem_stall, rti_commit;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        int_flag, stall_fetch, flush, stack_operation, push_pop, write_sp;
    logic        DMW, DMR, vector_load, int_pending;
    logic [3:0]  alu_function;
    logic [15:0] push_data, mem_addr;

    always #5 clk = ~clk;

    interrupt_ctrl_unit #(
        .PC_WIDTH(32), .DATA_WIDTH(16), .FLAG_WIDTH(3), .DRAIN_CYCLES(D), .VECTOR_ADDR(0)
    ) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .instr_boundary(instr_boundary),
        .mem_stall(mem_stall), .rti_commit(rti_commit), .pc_in(pc_in), .flags_in(flags_in),
        .int_flag(int_flag), .stall_fetch(stall_fetch), .flush(flush),
        .stack_operation(stack_operation), .push_pop(push_pop), .write_sp(write_sp),
        .DMW(DMW), .DMR(DMR), .alu_function(alu_function), .push_data(push_data),
        .mem_addr(mem_addr), .vector_load(vector_load), .int_pending(int_pending)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_prev_req;
    bit          m_pend;
    int          m_k;
    logic [31:0] m_spc;
    logic [2:0]  m_sflags;

    // Observation counters
    int          n_sp_upd, n_drain, n_dmw_cycles;
    logic [15:0] pushes[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [45:0] obs_vec();
        return {int_flag, stall_fetch, flush, stack_operation, push_pop, write_sp, DMW, DMR,
                alu_function, vector_load, int_pending, push_data, mem_addr};
    endfunction

    function automatic logic [45:0] model_vec();
        logic        in_srv, is_push, is_vec;
        logic [15:0] pd;
        in_srv  = (m_k >= 1) && (m_k <= D + 4);
        is_push = (m_k >= D + 1) && (m_k <= D + 3);
        is_vec  = (m_k == D + 4);
        pd = 16'h0000;
        if (m_k == D + 1)      pd = m_spc[31:16];
        else if (m_k == D + 2) pd = m_spc[15:0];
        else if (m_k == D + 3) pd = {13'b0, m_sflags};
        return {is_push | is_vec, in_srv, in_srv, is_push, is_push, is_push, is_push, is_vec,
                (is_push ? 4'b0100 : 4'b0000), is_vec, m_pend, pd, 16'h0000};
    endfunction

    function automatic void model_edge();
        bit rise, take;
        if (rst) begin
            m_prev_req = 1'b0; m_pend = 1'b0; m_k = 0; m_spc = '0; m_sflags = '0;
            return;
        end
        rise = int_req && !m_prev_req;
        take = (m_k == 0) && m_pend && instr_boundary && !mem_stall;
        if (m_k == 0) begin
            if (take) begin m_k = 1; m_spc = pc_in; end
        end else if (m_k <= D + 4) begin
            if (!mem_stall) begin
                if (m_k == D) m_sflags = flags_in;
                m_k++;
            end
        end else if (rti_commit) begin
            m_k = 0;
        end
        m_pend     = rise ? 1'b1 : (take ? 1'b0 : m_pend);
        m_prev_req = int_req;
    endfunction

    // One clock: note what the coming edge commits, advance model, compare.
    task automatic tick();
        if (!rst && write_sp && !mem_stall) n_sp_upd++;
        if (!rst && DMW && !mem_stall) pushes.push_back(push_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (DMW) n_dmw_cycles++;
        if (stall_fetch && flush && !int_flag) n_drain++;
        check("outputs", {18'b0, obs_vec()}, {18'b0, model_vec()});
    endtask

    task automatic clear_mon();
        n_sp_upd = 0; n_drain = 0; n_dmw_cycles = 0; pushes.delete();
    endtask

    task automatic pulse_int();
        int_req = 1'b1; tick(); int_req = 1'b0;
    endtask

    task automatic run_to_vector();
        int n = 0;
        while (!vector_load && n < 40) begin tick(); n++; end
        check("vector_reached", vector_load, 1);
    endtask

    task automatic finish_isr();
        tick(); rti_commit = 1'b1; tick(); rti_commit = 1'b0;
    endtask

    task automatic wait_push(input logic [15:0] word);
        int n = 0;
        while (!(DMW && push_data == word) && n < 40) begin tick(); n++; end
        check("push_reached", {DMW, push_data}, {1'b1, word});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; int_req = 1'b0; instr_boundary = 1'b0; mem_stall = 1'b0;
        rti_commit = 1'b0; pc_in = '0; flags_in = '0;
        clear_mon();

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", obs_vec(), 46'h0);

        // Single request, nominal sequence
        pc_in = 32'h0001_0A2C;
        flags_in = 3'((1 << CCR_C) | (1 << CCR_Z));
        instr_boundary = 1'b1;
        clear_mon();
        pulse_int();
        check("pending_latched", int_pending, 1);
        lat = 0;
        while (!vector_load && lat < 30) begin tick(); lat++; end
        // vector_load visible now; the PC loads on the next edge
        check("latency_to_vector", lat + 1, 1 + D + 3 + 1);
        check("vector_mem_addr", {DMR, mem_addr}, {1'b1, 16'h0000});
        check("drain_cycles", n_drain, D);
        check("push_count", pushes.size(), 3);
        check("push_pc_hi", (pushes.size() > 0) ? pushes[0] : 16'hxxxx, 16'h0001);
        check("push_pc_lo", (pushes.size() > 1) ? pushes[1] : 16'hxxxx, 16'h0A2C);
        check("push_flags", (pushes.size() > 2) ? pushes[2] : 16'hxxxx, 16'h0005);
        check("sp_updates", n_sp_upd, 3);
        finish_isr();
        check("back_to_idle", {int_flag, stall_fetch}, 2'b00);

        // Request away from an instruction boundary
        instr_boundary = 1'b0;
        pulse_int();
        repeat (2) begin
            tick();
            check("wait_boundary_pending", int_pending, 1);
            check("wait_boundary_no_drain", stall_fetch, 0);
        end
        instr_boundary = 1'b1;
        run_to_vector();
        finish_isr();

        // mem_stall during PUSH_LO
        clear_mon();
        pulse_int();
        wait_push(16'h0A2C);
        mem_stall = 1'b1;
        repeat (2) begin
            tick();
            check("stall_hold_word", {DMW, write_sp, push_data}, {2'b11, 16'h0A2C});
        end
        mem_stall = 1'b0;
        tick();
        check("after_stall_flags", push_data, 16'h0005);
        run_to_vector();
        check("stall_sp_updates", n_sp_upd, 3);
        check("stall_dmw_cycles", n_dmw_cycles, 5);

        // Requests during the ISR: one extra service only
        tick();
        clear_mon();
        pulse_int();
        repeat (5) tick();
        check("isr_masked_no_push", n_dmw_cycles, 0);
        check("isr_pending_kept", int_pending, 1);
        pulse_int();
        tick();
        rti_commit = 1'b1; tick(); rti_commit = 1'b0;
        run_to_vector();
        finish_isr();
        repeat (15) tick();
        check("one_extra_service", pushes.size(), 3);
        check("no_pending_left", int_pending, 0);

        // Reset during PUSH_HI
        clear_mon();
        pulse_int();
        wait_push(16'h0001);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_outputs", obs_vec(), 46'h0);
        repeat (10) tick();
        check("rst_mid_no_push", pushes.size(), 0);

        // rti_commit in IDLE is ignored
        rti_commit = 1'b1; tick(); rti_commit = 1'b0;
        check("rti_idle_outputs", obs_vec(), 46'h0);
        tick();
        check("rti_idle_stays", obs_vec(), 46'h0);

        // Random stimulus against the model
        repeat (3000) begin
            pc_in          = $urandom;
            flags_in       = 3'($urandom);
            int_req        = ($urandom_range(0, 5) == 0) ? ~int_req : int_req;
            instr_boundary = ($urandom_range(0, 3) != 0);
            mem_stall      = ($urandom_range(0, 3) == 0);
            rti_commit     = (m_k == D + 5) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 19) == 0);
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_interrupt_ctrl_unit

// File: doc/interrupt_ctrl_unit.md
Name: interrupt_ctrl_unit

Overview:
- Interrupt control unit. Sits upstream of the decode-stage control unit and drives its int_flag input.
- While int_flag=1 the control unit releases its shared stack and memory control lines. This block then drives those lines to save the return state: PC high word, PC low word, then flags.
- It then fetches the ISR vector and masks further interrupts until RTI commits.

Parameters:
PC_WIDTH, 32, program counter width; must be 2*DATA_WIDTH
DATA_WIDTH, 16, stack and memory word width
FLAG_WIDTH, 3, CCR width {C,N,Z}
DRAIN_CYCLES, 3, cycles allowed for in-flight instructions (EX/MEM/WB) to retire before the push sequence starts
VECTOR_ADDR, 0, data-memory address holding the ISR entry PC

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
int_req  in  1  external interrupt pin; a rising edge requests service
instr_boundary  in  1  fetch is at the first word of an instruction (not an immediate word)
mem_stall  in  1  data memory busy; holds the FSM in its current state
rti_commit  in  1  one-cycle pulse when RTI completes writeback
pc_in  in  PC_WIDTH  PC of the next instruction to fetch
flags_in  in  FLAG_WIDTH  current CCR
int_flag  out  1  ICU owns the shared control lines
stall_fetch  out  1  freeze the PC and IF/ID register
flush  out  1  inject NOP into decode
stack_operation  out  1  memory address comes from SP
push_pop  out  1  1 = push
write_sp  out  1  update SP
DMW  out  1  data memory write
DMR  out  1  data memory read
alu_function  out  4  ALU op while int_flag=1
push_data  out  DATA_WIDTH  word to be pushed
mem_addr  out  DATA_WIDTH  direct address used in the VECTOR state
vector_load  out  1  PC <= memory read data on the next edge
int_pending  out  1  request latched but not yet serviced

Behaviour:
- Edge detect: int_q registers int_req. rise = int_req & ~int_q.
- Pending latch:
  - Set on rise in any state.
  - Cleared on the IDLE->DRAIN transition.
  - One-deep: a rise while already pending is dropped.
  - A rise in the same cycle as the clear leaves pending set.
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VECTOR, IN_ISR.
- IDLE:
  - Go to DRAIN when pending & instr_boundary & ~mem_stall.
  - On that transition: saved_pc <= pc_in; drain_cnt <= DRAIN_CYCLES-1.
- DRAIN:
  - stall_fetch=1, flush=1, int_flag=0.
  - drain_cnt decrements each cycle and holds while mem_stall.
  - When drain_cnt==0 & ~mem_stall: saved_flags <= flags_in, go to PUSH_HI.
  - Result: exactly DRAIN_CYCLES cycles spent in DRAIN when no stall.
- PUSH_HI / PUSH_LO / PUSH_FLG:
  - Outputs: int_flag=1, stall_fetch=1, flush=1, stack_operation=1, push_pop=1, write_sp=1, DMW=1, alu_function=4'b0100 (pass operand 2).
  - push_data: saved_pc[31:16] in PUSH_HI, saved_pc[15:0] in PUSH_LO, zero-extended saved_flags in PUSH_FLG.
  - Each state takes one cycle. If mem_stall, hold the state and all outputs.
- VECTOR:
  - Outputs: int_flag=1, stall_fetch=1, flush=1, DMR=1, mem_addr=VECTOR_ADDR, vector_load=1, alu_function=0, all stack outputs 0.
  - Hold while mem_stall, otherwise go to IN_ISR.
- IN_ISR:
  - All control outputs 0; interrupts are masked (pending may still latch).
  - On rti_commit go to IDLE. A pending request then starts a new service at the next boundary.
- Nominal latency, request latched to vector loaded, no stalls: 1 (IDLE) + DRAIN_CYCLES + 3 + 1 = 8 cycles at defaults.
- Cycles with mem_stall=1 extend DRAIN, PUSH and VECTOR one-for-one.
- rti_commit outside IN_ISR is ignored.
- Reset:
  - State IDLE; pending, int_q, saved_pc, saved_flags and drain_cnt all cleared.
  - Every output 0, including push_data and mem_addr.
  - Reset mid-sequence aborts immediately with no further writes; a partial push is not unwound.
- All outputs are registered-state decodes, so outputs are never X or Z.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - state enumeration ICU_IDLE..ICU_IN_ISR;
  - ALU code PASS_OP2=4'b0100;
  - CCR bit indices C=2, N=1, Z=0;
  - VECTOR_ADDR default.
- Sub-module int_edge_latch: synchroniser flop, rise detect and pending latch (about 30 lines). The FSM and output decode stay in the top module.

Test Plan:
- Reset, then a single int_req pulse with instr_boundary=1 and pc_in=32'h0001_0A2C, flags_in=3'b101. Expect:
  - 3 DRAIN cycles with flush=1;
  - pushes of 16'h0001, then 16'h0A2C, then 16'h0005, each with DMW=1, push_pop=1, write_sp=1;
  - then DMR=1 with mem_addr=0 and vector_load=1;
  - 8 cycles from latch to vector, at defaults.
- int_req rises while instr_boundary=0 for 2 cycles. Expect int_pending=1 and no DRAIN entry until instr_boundary=1.
- mem_stall=1 for 2 cycles during PUSH_LO. Expect PUSH_LO outputs held for 3 cycles, a single SP update, and push_data=16'h0A2C held throughout.
- Second int_req rise during IN_ISR:
  - no new push sequence before rti_commit;
  - after rti_commit, a new service starts at the next boundary;
  - a third rise before servicing is dropped, so only one extra service occurs.
- rst asserted in PUSH_HI. Expect all outputs 0 on the next edge, state IDLE, int_pending=0, and no PUSH_LO.
- rti_commit pulsed in IDLE. Expect no state change; all outputs stay 0.
